fetch_unit: RTL and testbench

Instruction fetch stage for the cpu16 core. It sits directly upstream of the instruction ROM, drives its 16-bit word address, and captures the returned instruction word. Each word goes into a small prefetch buffer tagged with its PC. Decode consumes instructions over a valid/ready handshake. Execute can redirect fetch (jump/branch), which flushes all buffered words.

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage for cpu16: drives the ROM word address from the PC,
// captures the returned word into a small PC-tagged prefetch FIFO, and hands
// the head to decode over a valid/ready handshake. A redirect from execute
// reloads the PC and discards everything buffered.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  // Each entry is {instruction word, PC it was fetched from}.
  logic [31:0]   mem_q [DEPTH];

  logic push;
  logic pop;

  assign rom_addr    = pc_q;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push        = fetch_en & ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);
  assign busy        = instr_valid | fetch_en;

  // Head is forced to zero when empty so stale entries never leak out.
  assign instr    = instr_valid ? mem_q[rd_ptr_q][31:16] : 16'h0000;
  assign instr_pc = instr_valid ? mem_q[rd_ptr_q][15:0]  : 16'h0000;

  // Next-state: redirect flushes and reloads the PC, otherwise push/pop update.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 16'd1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset wins over redirect, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Buffer storage; contents are only observable through a valid count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {rom_data, pc_q};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random phase, all compared
// against a queue-based reference model of the fetch stage.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_ready = 1'b0;

  logic [15:0] rom_addr, rom_data, instr, instr_pc;
  logic        instr_valid, busy;
  logic [15:0] w_rom_addr, w_rom_data, w_instr, w_instr_pc;
  logic        w_instr_valid, w_busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_ok = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_f(input logic [15:0] a);
    case (a)
      16'h0000: rom_f = 16'h5655;
      16'h0001: rom_f = 16'h5811;
      16'h0002: rom_f = 16'h4800;
      16'h0003: rom_f = 16'hC261;
      16'h0008: rom_f = 16'h6804;
      16'h0009: rom_f = 16'hFFB0;
      16'h000A: rom_f = 16'hC914;
      16'hFFFF: rom_f = 16'h1234;
      default:  rom_f = a ^ 16'hA5C3;
    endcase
  endfunction

  assign rom_data   = rom_f(rom_addr);
  assign w_rom_data = rom_f(w_rom_addr);

  fetch_unit #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .busy(busy)
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle,
  // then advance the model by the same rising edge the DUT sees.
  task automatic step(input bit r, input bit fe, input bit rv,
                      input logic [15:0] rpc, input bit rdy);
    bit p_pop, p_push;
    rst = r; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    @(negedge clk);
    if (m_ok) begin
      chk("rom_addr", {16'h0, rom_addr}, {16'h0, m_pc});
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_q.size() != 0});
      chk("busy", {31'h0, busy}, {31'h0, (m_q.size() != 0) || fe});
      if (m_q.size() != 0) chk("head", {instr, instr_pc}, m_q[0]);
      else                 chk("head_idle", {instr, instr_pc}, 32'h0);
    end
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_pc = 16'h0000;
      m_ok = 1'b1;
    end else if (rv) begin
      m_q.delete();
      m_pc = rpc;
    end else begin
      p_pop  = (m_q.size() != 0) && rdy;
      p_push = fe && ((m_q.size() < DEPTH) || p_pop);
      if (p_pop) void'(m_q.pop_front());
      if (p_push) begin
        m_q.push_back({rom_f(m_pc), m_pc});
        m_pc = m_pc + 16'd1;
      end
    end
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] ei, input logic [15:0] ep);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, "_head"}, {instr, instr_pc}, {ei, ep});
  endtask

  initial begin
    // Reset state, including the FFFF-reset instance
    step(1, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    chk("rst_rom_addr", {16'h0, rom_addr}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_head", {instr, instr_pc}, 32'h0);
    chk("rst_w_rom_addr", {16'h0, w_rom_addr}, 32'h0000FFFF);

    // Straight-line fetch, and PC wrap on the FFFF-reset instance
    step(0, 1, 0, 16'h0, 1);
    chk_head("s1_0", 16'h5655, 16'h0000);
    chk("wrap_0", {w_instr, w_instr_pc}, {16'h1234, 16'hFFFF});
    step(0, 1, 0, 16'h0, 1);
    chk_head("s1_1", 16'h5811, 16'h0001);
    chk("wrap_1", {w_instr, w_instr_pc}, {16'h5655, 16'h0000});
    step(0, 1, 0, 16'h0, 1);
    chk_head("s1_2", 16'h4800, 16'h0002);
    step(0, 1, 0, 16'h0, 1);
    chk_head("s1_3", 16'hC261, 16'h0003);

    // Backpressure: buffer fills, PC holds at 2, head stays put
    step(1, 0, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0, 0);
    chk("bp_rom_addr", {16'h0, rom_addr}, 32'h2);
    chk_head("bp_hold", 16'h5655, 16'h0000);
    step(0, 1, 0, 16'h0, 1);
    chk_head("bp_1", 16'h5811, 16'h0001);
    step(0, 1, 0, 16'h0, 1);
    chk_head("bp_2", 16'h4800, 16'h0002);

    // Redirect mid-stream while instr_pc=1
    step(1, 0, 0, 16'h0, 0);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    chk_head("rd_pre", 16'h5811, 16'h0001);
    step(0, 1, 1, 16'h0008, 1);
    chk("rd_valid", {31'h0, instr_valid}, 32'h0);
    chk("rd_rom_addr", {16'h0, rom_addr}, 32'h8);
    step(0, 1, 0, 16'h0, 1);
    chk_head("rd_8", 16'h6804, 16'h0008);
    step(0, 1, 0, 16'h0, 1);
    chk_head("rd_9", 16'hFFB0, 16'h0009);

    // Redirect with concurrent pop on a full buffer
    step(1, 0, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0, 0);
    step(0, 1, 1, 16'h000A, 1);
    chk("rdf_valid", {31'h0, instr_valid}, 32'h0);
    step(0, 1, 0, 16'h0, 0);
    chk_head("rdf_A", 16'hC914, 16'h000A);

    // fetch_en=0 drains without fetching, then reset with a pending entry
    step(1, 0, 0, 16'h0, 0);
    step(0, 1, 0, 16'h0, 0);
    step(0, 1, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);
    chk_head("dr_1", 16'h5811, 16'h0001);
    chk("dr_rom_addr", {16'h0, rom_addr}, 32'h2);
    step(1, 1, 0, 16'h0, 1);
    chk("dr_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("dr_rst_rom_addr", {16'h0, rom_addr}, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 10), rpc, ($urandom_range(0, 99) < 60));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
